// File: rtl/ttpu_pkg.sv
// Shared tile-engine definitions: default geometry, matvec FSM states and element/address types.
package ttpu_pkg;

  localparam int MV_TILE      = 32;
  localparam int MV_DATA_W    = 16;
  localparam int MV_ACC_W     = 38;
  localparam int MV_FRAC_BITS = 8;
  localparam int MV_ADDR_W    = 20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } matvec_state_t;

  typedef logic signed [MV_DATA_W-1:0] elem_t;
  typedef logic signed [MV_ACC_W-1:0]  acc_t;
  typedef logic [MV_ADDR_W-1:0]        addr_t;

endpackage

// File: rtl/matvec_sat.sv
// One result lane: floor shift of the accumulator, saturation to DATA_W bits, and optional ReLU
// when MATVEC_RELU_EN is defined.
module matvec_sat
  import ttpu_pkg::*;
#(
  parameter int DATA_W    = MV_DATA_W,
  parameter int ACC_W     = MV_ACC_W,
  parameter int FRAC_BITS = MV_FRAC_BITS
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] y
);

  typedef logic signed [ACC_W-1:0]  wide_t;
  typedef logic signed [DATA_W-1:0] narrow_t;

  localparam wide_t SAT_MAX = wide_t'({1'b0, {(DATA_W-1){1'b1}}});
  localparam wide_t SAT_MIN = -SAT_MAX - wide_t'(1);

  function automatic wide_t shift_floor(input wide_t v);
    return v >>> FRAC_BITS;
  endfunction

  function automatic narrow_t sat(input wide_t v);
    if (v > SAT_MAX)
      return narrow_t'(SAT_MAX);
    else if (v < SAT_MIN)
      return narrow_t'(SAT_MIN);
    else
      return narrow_t'(v);
  endfunction

  function automatic narrow_t relu(input narrow_t v);
    return v[DATA_W-1] ? '0 : v;
  endfunction

  narrow_t s;

  always_comb begin
    s = sat(shift_floor(acc));
`ifdef MATVEC_RELU_EN
    y = relu(s);
`else
    y = s;
`endif
  end

endmodule

// File: rtl/matvec_engine.sv
// Column-serial y = A*x over one RAM tile with TILE parallel MAC lanes and a valid/ready result port.
// Build option MATVEC_RELU_EN (in matvec_sat) clamps negative results to zero.
module matvec_engine
  import ttpu_pkg::*;
#(
  parameter int TILE      = MV_TILE,
  parameter int DATA_W    = MV_DATA_W,
  parameter int ACC_W     = MV_ACC_W,
  parameter int FRAC_BITS = MV_FRAC_BITS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [MV_ADDR_W-1:0]          cfg_M,
  input  logic [MV_ADDR_W-1:0]          cfg_N,
  input  logic [MV_ADDR_W-1:0]          cfg_addr_matrix,
  input  logic [MV_ADDR_W-1:0]          cfg_addr_vector,
  output logic                          read_matrix,
  output logic                          read_vector,
  output logic [MV_ADDR_W-1:0]          matrix_M,
  output logic [MV_ADDR_W-1:0]          matrix_N,
  output logic [MV_ADDR_W-1:0]          vector_L,
  output logic [MV_ADDR_W-1:0]          address_matrix,
  output logic [MV_ADDR_W-1:0]          address_vector,
  input  logic [TILE*TILE*DATA_W-1:0]   matrix_in,
  input  logic [TILE*DATA_W-1:0]        vector_in,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [TILE*DATA_W-1:0]        result
);

  localparam int CW = (TILE > 1) ? $clog2(TILE) : 1;
  localparam logic [MV_ADDR_W-1:0] TILE_A = MV_ADDR_W'(TILE);

  function automatic logic [MV_ADDR_W-1:0] clamp(input logic [MV_ADDR_W-1:0] v);
    return (v > TILE_A) ? TILE_A : v;
  endfunction

  matvec_state_t state_q, state_d;
  logic [CW-1:0]  col_q;
  logic           accept;
  logic           acc_en;
  logic           last_col;
  logic signed [DATA_W-1:0] x_col;

  assign accept   = (state_q == IDLE) && start;
  assign acc_en   = (state_q == COMPUTE);
  assign last_col = (MV_ADDR_W'(col_q) == matrix_N - MV_ADDR_W'(1));
  assign x_col    = vector_in[int'(col_q)*DATA_W +: DATA_W];

  always_comb begin
    state_d     = state_q;
    read_matrix = 1'b0;
    read_vector = 1'b0;
    busy        = 1'b1;
    out_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        read_matrix = 1'b1;
        read_vector = 1'b1;
        state_d     = (matrix_N == '0) ? DONE : COMPUTE;
      end
      COMPUTE: begin
        if (last_col) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The tile itself is never copied; the RAM outputs stay stable for the whole run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      col_q          <= '0;
      matrix_M       <= '0;
      matrix_N       <= '0;
      vector_L       <= '0;
      address_matrix <= '0;
      address_vector <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        matrix_M       <= clamp(cfg_M);
        matrix_N       <= clamp(cfg_N);
        vector_L       <= clamp(cfg_N);
        address_matrix <= cfg_addr_matrix;
        address_vector <= cfg_addr_vector;
        col_q          <= '0;
      end else if (acc_en) begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  for (genvar r = 0; r < TILE; r++) begin : g_lane
    logic signed [DATA_W-1:0]   a_el;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_p0;
    logic                       row_en;

    assign a_el   = matrix_in[(r*TILE + int'(col_q))*DATA_W +: DATA_W];
    assign prod   = a_el * x_col;
    assign row_en = acc_en && (MV_ADDR_W'(r) < matrix_M);

    // MAC stage: rows at or beyond M stay at their cleared value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        acc_p0 <= '0;
      else if (accept)
        acc_p0 <= '0;
      else if (row_en)
        acc_p0 <= acc_p0 + ACC_W'(prod);
    end

    matvec_sat #(
      .DATA_W    (DATA_W),
      .ACC_W     (ACC_W),
      .FRAC_BITS (FRAC_BITS)
    ) u_sat (
      .acc (acc_p0),
      .y   (result[r*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_matvec_engine.sv
// Randomized scoreboard bench for matvec_engine: a RAM stub feeds tiles, a plain-arithmetic model
// predicts each result vector, and a monitor compares on every accepted output transfer.
module tb_matvec_engine;
  import ttpu_pkg::*;

  localparam int TILE = MV_TILE;
  localparam int DW   = MV_DATA_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic [19:0] cfg_M = '0, cfg_N = '0, cfg_addr_matrix = '0, cfg_addr_vector = '0;
  logic read_matrix, read_vector, busy, out_valid;
  logic [19:0] matrix_M, matrix_N, vector_L, address_matrix, address_vector;
  logic [TILE*TILE*DW-1:0] matrix_in = '0;
  logic [TILE*DW-1:0] vector_in = '0;
  logic [TILE*DW-1:0] result;

  logic signed [DW-1:0] A [TILE][TILE];
  logic signed [DW-1:0] x [TILE];
  logic [TILE*DW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  matvec_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_M(cfg_M), .cfg_N(cfg_N),
    .cfg_addr_matrix(cfg_addr_matrix), .cfg_addr_vector(cfg_addr_vector),
    .read_matrix(read_matrix), .read_vector(read_vector),
    .matrix_M(matrix_M), .matrix_N(matrix_N), .vector_L(vector_L),
    .address_matrix(address_matrix), .address_vector(address_vector),
    .matrix_in(matrix_in), .vector_in(vector_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  // RAM stub: registers the staged tile on the read strobes.
  always @(posedge clk) begin
    if (read_matrix)
      for (int r = 0; r < TILE; r++)
        for (int c = 0; c < TILE; c++)
          matrix_in[(r*TILE+c)*DW +: DW] <= A[r][c];
    if (read_vector)
      for (int c = 0; c < TILE; c++)
        vector_in[c*DW +: DW] <= x[c];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // y[r] = clamp(floor(sum_c A[r][c]*x[c] / 256)) for r < m, else 0.
  function automatic logic [TILE*DW-1:0] model(input int m, input int n);
    logic [TILE*DW-1:0] res;
    longint s, q;
    res = '0;
    for (int r = 0; r < TILE; r++) begin
      s = 0;
      if (r < m)
        for (int c = 0; c < n; c++)
          s += longint'(A[r][c]) * longint'(x[c]);
      q = s >>> MV_FRAC_BITS;
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
`ifdef MATVEC_RELU_EN
      if (q < 0) q = 0;
`endif
      res[r*DW +: DW] = q[DW-1:0];
    end
    return res;
  endfunction

  task automatic fill_rand(input int lim);
    for (int r = 0; r < TILE; r++) begin
      for (int c = 0; c < TILE; c++)
        A[r][c] = (lim == 0) ? DW'($urandom) : DW'($urandom_range(0, 2*lim) - lim);
      x[r] = (lim == 0) ? DW'($urandom) : DW'($urandom_range(0, 2*lim) - lim);
    end
  endtask

  task automatic fill_const(input logic [DW-1:0] av, input logic [DW-1:0] xv);
    for (int r = 0; r < TILE; r++) begin
      for (int c = 0; c < TILE; c++)
        A[r][c] = av;
      x[r] = xv;
    end
  endtask

  task automatic run_tile(input int m, input int n, input int hold, input bit early);
    int mc, nc, lat;
    logic [19:0] am, av;
    logic [TILE*DW-1:0] snap;
    mc = (m > TILE) ? TILE : m;
    nc = (n > TILE) ? TILE : n;
    am = 20'($urandom);
    av = 20'($urandom);
    exp_q.push_back(model(mc, nc));
    cfg_M = 20'(m);
    cfg_N = 20'(n);
    cfg_addr_matrix = am;
    cfg_addr_vector = av;
    start = 1'b1;
    out_ready = early;
    tick;
    start = 1'b0;
    chk("fetch_read_matrix", 64'(read_matrix), 64'(1));
    chk("fetch_read_vector", 64'(read_vector), 64'(1));
    chk("fetch_busy", 64'(busy), 64'(1));
    chk("matrix_M", 64'(matrix_M), 64'(mc));
    chk("matrix_N", 64'(matrix_N), 64'(nc));
    chk("vector_L", 64'(vector_L), 64'(nc));
    chk("address_matrix", 64'(address_matrix), 64'(am));
    chk("address_vector", 64'(address_vector), 64'(av));
    cfg_M = 20'($urandom);
    cfg_N = 20'($urandom);
    cfg_addr_matrix = 20'($urandom);
    lat = 0;
    do begin
      tick;
      lat++;
      if (lat == 1) chk("fetch_one_cycle", 64'(read_matrix), 64'(0));
    end while (!out_valid && lat < 200);
    chk("latency", 64'(lat), 64'((nc == 0) ? 1 : nc + 1));
    if (!early) begin
      snap = result;
      for (int i = 0; i < hold; i++) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_busy", 64'(busy), 64'(1));
        chk("hold_stable", 64'(result == snap), 64'(1));
        start = 1'($urandom_range(0, 1));
        cfg_M = 20'($urandom);
        tick;
      end
      start = 1'b0;
      chk("hold_cfg_kept", 64'(matrix_M), 64'(mc));
      out_ready = 1'b1;
    end
    tick;
    out_ready = 1'b0;
    chk("valid_drop", 64'(out_valid), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_read"}, 64'({read_matrix, read_vector}), 64'(0));
    chk({tag, "_cfg"}, 64'({matrix_M, matrix_N, vector_L}), 64'(0));
    chk({tag, "_addr"}, 64'({address_matrix, address_vector}), 64'(0));
    chk({tag, "_result"}, 64'(result == '0), 64'(1));
  endtask

  // Scoreboard monitor: one comparison per accepted transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin : mon
      logic [TILE*DW-1:0] e;
      int bad;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected: output transfer with no expected entry");
      end else begin
        e = exp_q.pop_front();
        bad = -1;
        for (int r = TILE - 1; r >= 0; r--)
          if (result[r*DW +: DW] !== e[r*DW +: DW]) bad = r;
        if (bad >= 0) begin
          errors++;
          $display("FAIL result lane %0d: got %h expected %h", bad,
                   result[bad*DW +: DW], e[bad*DW +: DW]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) tick;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick;

    // Abort a full tile partway through COMPUTE.
    fill_rand(0);
    cfg_M = 20'd32;
    cfg_N = 20'd32;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (11) tick;
    chk("mid_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    tick;
    tick;
    rst_n = 1'b1;
    tick;

    fill_rand(0);
    run_tile(2, 2, 3, 1'b0);

    fill_rand(0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        A[r][c] = (r == c) ? 16'h0100 : 16'h0000;
    x[0] = 16'h0100;
    x[1] = 16'h0200;
    x[2] = 16'hFF00;
    x[3] = 16'h0080;
    run_tile(4, 4, 2, 1'b0);

    fill_const(16'h7FFF, 16'h7FFF);
    run_tile(32, 32, 0, 1'b1);
    fill_const(16'h7FFF, 16'h8000);
    run_tile(32, 32, 1, 1'b0);

    fill_rand(0);
    run_tile(5, 0, 1, 1'b0);

    fill_rand(300);
    run_tile(7, 9, 20, 1'b0);

    fill_rand(0);
    run_tile(40, 33, 1, 1'b0);

    repeat (20) begin
      fill_rand(($urandom_range(0, 1) == 0) ? 0 : 200);
      run_tile(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
               int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matvec_engine.md
# matvec_engine

Tile-level matrix-vector multiply stage that sits directly downstream of the on-chip RAM. It requests a matrix tile and a vector tile from the RAM, then computes y = A·x column-serially, with 32 parallel multiply-accumulate lanes (one lane per row). It presents the saturated 16-bit result vector to the next stage with a valid/ready handshake.

## Interface

Parameters:
- TILE, 32, tile edge; rows and columns processed per tile
- DATA_W, 16, signed element width (matrix, vector, result)
- ACC_W, 38, signed accumulator width
- FRAC_BITS, 8, arithmetic right shift applied before saturation (Q8.8)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request one tile multiply; sampled only in IDLE
- cfg_M  in  20  rows of A (valid rows of result)
- cfg_N  in  20  columns of A (length of x)
- cfg_addr_matrix  in  20  RAM base address of A
- cfg_addr_vector  in  20  RAM base address of x
- read_matrix  out  1  RAM tile-read strobe
- read_vector  out  1  RAM vector-read strobe
- matrix_M, matrix_N, vector_L  out  20 each  latched cfg_M, cfg_N, cfg_N to RAM
- address_matrix, address_vector  out  20 each  latched base addresses to RAM
- matrix_in  in  TILE×TILE×DATA_W  RAM matrix tile output
- vector_in  in  TILE×DATA_W  RAM vector tile output
- busy  out  1  high in every state except IDLE
- out_valid  out  1  result vector valid
- out_ready  in  1  downstream accepts result
- result  out  TILE×DATA_W  y[0..TILE-1]

## Operation

- States: IDLE, FETCH, COMPUTE, DONE.
- IDLE, start=1: latch cfg_* into the RAM-facing outputs, clamping M and N to TILE. Clear all accumulators and the column counter, then go to FETCH.
- FETCH (exactly 1 cycle): read_matrix=1 and read_vector=1. The RAM registers the tile at this edge. Next state is COMPUTE, or DONE directly if N=0.
- COMPUTE: column counter c runs 0..N-1, one column per cycle.
  - For each row r<M: acc[r] += matrix_in[r][c] * vector_in[c] (signed 16×16→32, sign-extended to ACC_W).
  - Rows r≥M do not accumulate.
  - After c=N-1, go to DONE.
- The engine holds no copy of the tile. It relies on the RAM outputs staying stable because the engine is the only tile reader; no other agent issues a tile read while busy=1.
- DONE: out_valid=1.
  - result[r] = sat16(acc[r] >>> FRAC_BITS) for r<M, and 0 for r≥M.
  - Rounding is floor (arithmetic shift). Saturation range is [-32768, 32767].
  - When out_valid && out_ready, go to IDLE.
- start is ignored in FETCH, COMPUTE and DONE; no queuing.
- cfg_* changes after acceptance have no effect on the running tile.

## Timing

- Reset (async assert, sync-free deassert) gives state=IDLE.
  - busy, out_valid, read_matrix and read_vector are 0.
  - result, all accumulators, the counter and all latched cfg/address outputs are 0.
- Reset asserted mid-operation aborts immediately; no result is produced.
- Latency: start sampled at edge E0, FETCH occupies cycle E0→E1, and COMPUTE occupies edges E2..E(N+1). out_valid rises after edge E(N+1), i.e. N+1 cycles after E0 for N≥1; for N=0 it rises after E1.
- result is registered, stable, and unchanged while out_valid=1 and out_ready=0.
- out_ready may be high before out_valid. The transfer completes on the first edge where both are 1, and out_valid drops after that edge.
- Earliest re-start: start sampled on the edge after the transfer edge (IDLE lasts ≥1 cycle).

## Configuration

- MATVEC_RELU_EN defined: result[r] = max(0, sat16(acc[r] >>> FRAC_BITS)), i.e. negative results are forced to 0.
- MATVEC_RELU_EN undefined: signed saturated result is passed unchanged. Latency is identical in both builds.

## Structure

- Shared package ttpu_pkg holds:
  - TILE, DATA_W, ACC_W, FRAC_BITS defaults
  - the matvec_state_t enum (IDLE, FETCH, COMPUTE, DONE)
  - element, accumulator and 20-bit address typedefs
- Sub-module matvec_sat: combinational shift, saturate and optional ReLU for one lane, instantiated TILE times.

## Test plan

- Reset mid-COMPUTE (N=32, rst_n low at c=10) -> all outputs 0 immediately; later start with M=N=2 completes normally.
- Identity A (M=N=4, diag=0x0100), x={0x0100,0x0200,-0x0100,0x0080} -> result={0x0100,0x0200,0xFF00,0x0080}, rest 0. out_valid appears 5 cycles after start.
- M=N=32, all A=0x7FFF, x=0x7FFF -> every result=0x7FFF. With A=0x7FFF and x=0x8000 -> 0x8000; with MATVEC_RELU_EN -> 0.
- N=0, M=5 -> result all 0, out_valid rises after 2 edges, and no COMPUTE cycles occur.
- out_ready held low 20 cycles in DONE, with start pulsed and cfg changed -> result stable, start ignored, busy=1. Transfer occurs on the first out_ready edge.
- cfg_M=40, cfg_N=33 -> clamped to 32: matrix_M=32, matrix_N=32, and COMPUTE lasts 32 cycles.
